// File: rtl/data_memory_mmio_if.sv
// Load/store port of the core plus the GPIO output stream of the data memory.
// The core drives we/addr/wd and the GPIO consumer drives gpio_ready.
interface data_memory_mmio_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int GPIO_W = 8
);
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wd;
   logic [DATA_W-1:0] rd;
   logic [GPIO_W-1:0] gpio_data;
   logic              gpio_valid;
   logic              gpio_ready;
   logic              gpio_overflow;

   modport master (
      output we, addr, wd, gpio_ready,
      input  rd, gpio_data, gpio_valid, gpio_overflow
   );

   modport slave (
      input  we, addr, wd, gpio_ready,
      output rd, gpio_data, gpio_valid, gpio_overflow
   );
endinterface

// File: rtl/data_memory_mmio.sv
// Data memory for the single-cycle core: byte region, word scratch region,
// a buffered GPIO output FIFO and a status register, all on one load/store port.
module data_memory_mmio #(
   parameter int BYTE_DEPTH  = 152100,
   parameter int WORD_DEPTH  = 1536,
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int GPIO_W      = 8,
   parameter int FIFO_DEPTH  = 8,
   parameter bit GPIO_MIRROR = 1'b1
) (
   input logic               clk,
   input logic               rst_n,
   data_memory_mmio_if.slave bus
);
   localparam int BA_W = $clog2(BYTE_DEPTH);
   localparam int WA_W = $clog2(WORD_DEPTH);
   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int CW   = PW + 1;

   localparam logic [ADDR_W-1:0] WORD_BASE   = ADDR_W'(BYTE_DEPTH);
   localparam logic [ADDR_W-1:0] GPIO_ADDR   = ADDR_W'(BYTE_DEPTH + WORD_DEPTH);
   localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(BYTE_DEPTH + WORD_DEPTH + 1);

   logic [7:0]        bmem [BYTE_DEPTH];
   logic [DATA_W-1:0] wmem [WORD_DEPTH];
   logic [GPIO_W-1:0] fmem [FIFO_DEPTH];

   logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;

   logic            in_byte, in_word, in_gpio, in_stat;
   logic [BA_W-1:0] bidx;
   logic [WA_W-1:0] widx;
   logic            full, empty, push_req, push, pop, ovf_set, ovf_clr;
   logic [31:0]     cnt_ext, status;
   logic [7:0]      cnt8;

   // Address decode; anything above STATUS_ADDR matches no region.
   always_comb begin
      in_byte = (bus.addr < WORD_BASE);
      in_word = !in_byte && (bus.addr < GPIO_ADDR);
      in_gpio = (bus.addr == GPIO_ADDR);
      in_stat = (bus.addr == STATUS_ADDR);
      bidx    = BA_W'(bus.addr);
      widx    = WA_W'(bus.addr - WORD_BASE);
   end

   always_comb begin
      empty    = (cnt_q == '0);
      full     = (cnt_q == CW'(FIFO_DEPTH));
      pop      = !empty && bus.gpio_ready;
      push_req = bus.we && (in_gpio || (GPIO_MIRROR && in_byte));
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      push     = push_req && (!full || pop);
      ovf_set  = push_req && full && !pop;
      ovf_clr  = bus.we && in_stat && bus.wd[31];
   end

   always_comb begin
      rptr_d = rptr_q;
      wptr_d = wptr_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
      if (ovf_clr) ovf_d = 1'b0;
      if (ovf_set) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rptr_q <= '0;
         wptr_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) fmem[i] <= '0;
      end else begin
         rptr_q <= rptr_d;
         wptr_q <= wptr_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
         if (push) fmem[wptr_q] <= bus.wd[GPIO_W-1:0];
      end
   end

   // Bulk memories keep their contents across rst_n.
   always_ff @(posedge clk) begin
      if (bus.we && in_byte) bmem[bidx] <= bus.wd[7:0];
   end

   always_ff @(posedge clk) begin
      if (bus.we && in_word) wmem[widx] <= bus.wd;
   end

   always_comb begin
      cnt_ext    = 32'(cnt_q);
      cnt8       = (cnt_ext > 32'd255) ? 8'hFF : cnt_ext[7:0];
      status     = '0;
      status[31] = ovf_q;
      status[9]  = full;
      status[8]  = empty;
      status[7:0] = cnt8;
   end

   always_comb begin
      bus.rd = '0;
      if (in_byte)      bus.rd = DATA_W'(bmem[bidx]);
      else if (in_word) bus.rd = wmem[widx];
      else if (in_gpio) bus.rd = empty ? '0 : DATA_W'(fmem[rptr_q]);
      else if (in_stat) bus.rd = DATA_W'(status);
   end

   assign bus.gpio_data     = fmem[rptr_q];
   assign bus.gpio_valid    = !empty;
   assign bus.gpio_overflow = ovf_q;
endmodule

// File: tb/tb_data_memory_mmio.sv
// Scoreboard bench for data_memory_mmio: expected load data and GPIO entries are
// queued by stimulus and popped by monitors when the DUT presents them.
module tb_data_memory_mmio;
   localparam int B = 152100;
   localparam int W = 1536;
   localparam logic [31:0] GPIO_A = 32'(B + W);
   localparam logic [31:0] STAT_A = 32'(B + W + 1);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   data_memory_mmio_if #(.DATA_W(32), .ADDR_W(32), .GPIO_W(8)) bus ();
   data_memory_mmio_if #(.DATA_W(32), .ADDR_W(32), .GPIO_W(8)) mbus ();

   data_memory_mmio #(.GPIO_MIRROR(1'b0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   data_memory_mmio #(.GPIO_MIRROR(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(mbus.slave));

   int passed = 0;
   int total  = 0;

   logic [31:0] rd_q[$];
   logic [7:0]  gq[$];
   logic [7:0]  mgq[$];
   logic        rd_go = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Monitors sample mid-cycle; a handshake seen here completes at the next edge.
   always @(negedge clk) begin
      logic [31:0] e32;
      logic [7:0]  e8;
      if (rd_go) begin
         if (rd_q.size() == 0) check("rd_unexpected", bus.rd, 32'hFFFF_FFFF);
         else begin
            e32 = rd_q.pop_front();
            check("rd", bus.rd, e32);
         end
      end
      if (bus.gpio_valid && bus.gpio_ready) begin
         if (gq.size() == 0) check("gpio_unexpected", 32'(bus.gpio_data), 32'hFFFF_FFFF);
         else begin
            e8 = gq.pop_front();
            check("gpio_data", 32'(bus.gpio_data), 32'(e8));
         end
      end
      if (mbus.gpio_valid && mbus.gpio_ready) begin
         if (mgq.size() == 0) check("mgpio_unexpected", 32'(mbus.gpio_data), 32'hFFFF_FFFF);
         else begin
            e8 = mgq.pop_front();
            check("mgpio_data", 32'(mbus.gpio_data), 32'(e8));
         end
      end
   end

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.we = 1'b1; bus.addr = a; bus.wd = d;
      @(posedge clk); #1;
      bus.we = 1'b0;
   endtask

   task automatic gpush(input logic [7:0] d);
      gq.push_back(d);
      wr(GPIO_A, 32'(d));
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp);
      bus.addr = a;
      rd_q.push_back(exp);
      rd_go = 1'b1;
      @(posedge clk); #1;
      rd_go = 1'b0;
   endtask

   initial begin
      bus.we = 1'b0; bus.addr = '0; bus.wd = '0; bus.gpio_ready = 1'b0;
      mbus.we = 1'b0; mbus.addr = '0; mbus.wd = '0; mbus.gpio_ready = 1'b0;
      #12;
      check("rst_valid", 32'(bus.gpio_valid), 32'd0);
      check("rst_ovf", 32'(bus.gpio_overflow), 32'd0);
      check("rst_gpio_data", 32'(bus.gpio_data), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      rd(STAT_A, 32'h0000_0100);

      // Byte and word regions, out-of-range read.
      wr(32'd10, 32'h0000_00A5);
      rd(32'd10, 32'h0000_00A5);
      rd(STAT_A + 32'd4, 32'h0);
      wr(32'd152100, 32'hDEAD_BEEF);
      rd(32'd152100, 32'hDEAD_BEEF);
      wr(32'd152099, 32'hFFFF_FF5C);
      rd(32'd152099, 32'h0000_005C);
      wr(STAT_A + 32'd4, 32'h1234_5678);
      rd(STAT_A + 32'd4, 32'h0);

      // Fill the FIFO with the consumer stalled, then overflow it.
      for (int i = 0; i < 8; i++) gpush(8'(8'h11 + i));
      rd(STAT_A, 32'h0000_0208);
      rd(GPIO_A, 32'h0000_0011);
      wr(GPIO_A, 32'h19);
      check("ovf_set", 32'(bus.gpio_overflow), 32'd1);
      rd(STAT_A, 32'h8000_0208);
      wr(STAT_A, 32'h0000_0000);
      check("ovf_keep", 32'(bus.gpio_overflow), 32'd1);
      wr(STAT_A, 32'h8000_0000);
      check("ovf_clr", 32'(bus.gpio_overflow), 32'd0);
      rd(STAT_A, 32'h0000_0208);

      // Full FIFO, push and pop in the same cycle.
      bus.gpio_ready = 1'b1;
      gq.push_back(8'h2A);
      bus.we = 1'b1; bus.addr = GPIO_A; bus.wd = 32'h2A;
      @(posedge clk); #1;
      bus.we = 1'b0; bus.gpio_ready = 1'b0;
      check("pp_ovf", 32'(bus.gpio_overflow), 32'd0);
      rd(STAT_A, 32'h0000_0208);

      // Drain.
      bus.gpio_ready = 1'b1;
      for (int i = 0; i < 20 && bus.gpio_valid; i++) begin
         @(posedge clk); #1;
      end
      bus.gpio_ready = 1'b0;
      check("drain_valid", 32'(bus.gpio_valid), 32'd0);
      check("drain_left", 32'(gq.size()), 32'd0);
      rd(STAT_A, 32'h0000_0100);

      // Byte write with mirroring disabled does not push.
      wr(32'd500, 32'h7E);
      check("nomirror_valid", 32'(bus.gpio_valid), 32'd0);

      // Mirroring enabled: byte write pushes, visible one cycle later.
      mbus.we = 1'b1; mbus.addr = 32'd500; mbus.wd = 32'h7E;
      mgq.push_back(8'h7E);
      #1 check("mirror_nobypass", 32'(mbus.gpio_valid), 32'd0);
      @(posedge clk); #1;
      mbus.we = 1'b0;
      check("mirror_valid", 32'(mbus.gpio_valid), 32'd1);
      mbus.gpio_ready = 1'b1;
      @(posedge clk); #1;
      mbus.gpio_ready = 1'b0;
      check("mirror_empty", 32'(mbus.gpio_valid), 32'd0);
      check("mirror_left", 32'(mgq.size()), 32'd0);

      // Reset in the middle of a drain.
      for (int i = 0; i < 4; i++) gpush(8'(8'h31 + i));
      bus.gpio_ready = 1'b1;
      @(posedge clk); #1;
      bus.gpio_ready = 1'b0;
      rd(STAT_A, 32'h0000_0003);
      #2 rst_n = 1'b0;
      #1 check("async_valid", 32'(bus.gpio_valid), 32'd0);
      gq.delete();
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      rd(STAT_A, 32'h0000_0100);
      rd(32'd10, 32'h0000_00A5);
      rd(32'd152100, 32'hDEAD_BEEF);
      check("rd_left", 32'(rd_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/data_memory_mmio.md
Name: data_memory_mmio

Overview:
- Parametrised successor of the CPU data memory, sitting on the single-cycle core's load/store port.
- Provides a byte-addressed image region, a word-wide scratch region and a memory-mapped GPIO output channel.
- The GPIO channel is a FIFO with a valid/ready handshake, replacing the old unbuffered GPIO/GPIOEn mirror.
- Exposes status and overflow through a readable register.

Parameters:
- BYTE_DEPTH, 152100, entries in the byte region; each entry stores 8 bits.
- WORD_DEPTH, 1536, entries in the word region; each entry stores DATA_W bits.
- DATA_W, 32, data bus width.
- ADDR_W, 32, address bus width.
- GPIO_W, 8, width of one GPIO FIFO entry.
- FIFO_DEPTH, 8, GPIO FIFO entries; power of two, at least 2.
- GPIO_MIRROR, 1:
  - 1 = every byte-region write also pushes wd[GPIO_W-1:0] into the FIFO (legacy mode).
  - 0 = only writes to GPIO_ADDR push.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  store enable from the core.
- addr  in  ADDR_W  byte/word address from the core.
- wd  in  DATA_W  store data.
- rd  out  DATA_W  load data, combinational from addr.
- gpio_data  out  GPIO_W  FIFO head entry.
- gpio_valid  out  1  FIFO non-empty.
- gpio_ready  in  1  consumer accepts the head when high with gpio_valid.
- gpio_overflow  out  1  sticky flag: a push was dropped.

Behaviour:
- Address map, with B = BYTE_DEPTH and W = WORD_DEPTH:
  - Byte region: [0, B-1].
  - Word region: [B, B+W-1], indexed by addr-B.
  - GPIO_ADDR = B+W.
  - STATUS_ADDR = B+W+1.
  - Any address above STATUS_ADDR: reads return 0, writes are ignored.
- Reads (combinational):
  - Byte region: zero-extended 8-bit entry.
  - Word region: full word.
  - GPIO_ADDR: zero-extended current head (0 if empty); does not pop.
  - STATUS_ADDR: bit31 = overflow, bit9 = full, bit8 = empty, bits[7:0] = count. Count is saturated at 255; all other bits are 0.
- Writes (rising edge, when we=1):
  - Byte region: stores wd[7:0]. Word region: stores wd.
  - GPIO_ADDR: push request with wd[GPIO_W-1:0].
  - Byte region with GPIO_MIRROR=1: also a push request.
  - STATUS_ADDR: clears overflow when wd[31]=1; nothing else is writable.
- Memory arrays are not reset; their contents survive rst_n.
- FIFO:
  - Circular buffer with read pointer, write pointer and count of width clog2(FIFO_DEPTH)+1.
  - Pointers wrap modulo FIFO_DEPTH.
  - pop = gpio_valid & gpio_ready.
  - gpio_valid = (count != 0). gpio_data = mem[rptr], registered storage.
- No bypass: a push into an empty FIFO makes gpio_valid high on the next cycle.
- Latency from push to visible: 1 cycle.
- Simultaneous events:
  - Push and pop when not full: both occur, count unchanged, order preserved.
  - Push when full with pop in the same cycle: both occur, no overflow.
  - Push when full without pop: data dropped, overflow set, FIFO unchanged.
  - Pop when empty: impossible, since gpio_valid=0.
  - Overflow set and clear in the same cycle: set wins.
- Reset values: gpio_valid=0, gpio_overflow=0, count=0, pointers=0, gpio_data=0.
  - Reset mid-transfer discards FIFO contents.
  - gpio_valid drops asynchronously with rst_n.
- gpio_overflow mirrors the status bit31 register.

Test Plan:
- Reset, then write 0x000000A5 to addr 10 and read addr 10 -> rd=0x000000A5. Read addr 153636+5 (out of range) -> rd=0.
- Write 0xDEADBEEF to addr 152100, read it back -> rd=0xDEADBEEF. Read addr 152099 -> byte value only, upper 24 bits zero.
- Hold gpio_ready=0 and write 0x11..0x18 to GPIO_ADDR (153636):
  - Status read shows count=8, full=1.
  - A 9th write of 0x19 sets gpio_overflow=1 and leaves the FIFO unchanged.
  - Raise gpio_ready -> gpio_data sequence is 0x11..0x18, then gpio_valid=0.
- Full FIFO, gpio_ready=1, and a push of 0x2A in the same cycle -> count stays 8, gpio_overflow stays 0, 0x2A emerges last.
- GPIO_MIRROR=1: a byte write of 0x7E to addr 500 -> gpio_data=0x7E, valid the next cycle. GPIO_MIRROR=0: same write -> gpio_valid stays 0.
- Overflow set, then write 0x80000000 to STATUS_ADDR -> overflow clears.
- Assert rst_n=0 mid-drain with 3 entries queued -> gpio_valid=0 immediately, count=0 after release, byte-region data still readable.
